// File: rtl/rgb2bayer_tx.sv
// ---------------------------------------------------------------------------
// rgb2bayer_tx
//
// Sensor-side transmitter that turns a stream of 12-bit RGB pixels into a
// single 12-bit Bayer raw stream. The stream carries the same CCD-style frame
// and line timing (FVAL, LVAL, X/Y counters) as the D8M camera front end.
// Use it to drive the raw capture / demosaic path from a software-generated
// or looped-back image when no camera is attached.
//
// Frame layout, in pixel clocks:
//   V_LEAD  : FV_LEAD cycles, FVAL high, LVAL low
//   LINE    : H_ACTIVE cycles, FVAL and LVAL high, one pixel consumed each
//   H_GAP   : H_BLANK cycles between lines, FVAL high, LVAL low
//   V_GAP   : V_BLANK cycles after the last line, FVAL low
//
// Ports:
//   CCD_PIXCLK   in   1  pixel clock, all logic on its rising edge
//   RST_N        in   1  synchronous active-low reset
//   iENABLE      in   1  start frames; looked at in IDLE and at the end of V_GAP
//   iRed         in  12  red component of the offered pixel
//   iGreen       in  12  green component of the offered pixel
//   iBlue        in  12  blue component of the offered pixel
//   iVALID       in   1  offered pixel is valid
//   oREADY       out  1  offered pixel is consumed this cycle (LINE only)
//   mCCD_DATA    out 12  Bayer raw sample (registered)
//   CCD_FVAL     out  1  frame valid (registered)
//   CCD_LVAL     out  1  line valid (registered)
//   X_Cont       out 16  column of the current sample, 0 when LVAL is low
//   Y_Cont       out 16  row of the current sample, 0 when LVAL is low
//   oUNDERRUN    out  1  sticky: a pixel was missing in the current frame
//   oFRAME_DONE  out  1  one-cycle pulse with the last pixel of a frame
// ---------------------------------------------------------------------------
module rgb2bayer_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 160,
  parameter int V_BLANK     = 2000,
  parameter int FV_LEAD     = 4,
  parameter int BAYER_ORDER = 0
) (
  input  logic        CCD_PIXCLK,
  input  logic        RST_N,
  input  logic        iENABLE,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic        iVALID,
  output logic        oREADY,
  output logic [11:0] mCCD_DATA,
  output logic        CCD_FVAL,
  output logic        CCD_LVAL,
  output logic [15:0] X_Cont,
  output logic [15:0] Y_Cont,
  output logic        oUNDERRUN,
  output logic        oFRAME_DONE
);

  // Terminal counts for the position and blanking counters.
  localparam logic [15:0] H_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
  localparam logic [15:0] FL_LAST = 16'(FV_LEAD - 1);

  // Mosaic phase: RGGB=00, GRBG=01, GBRG=10, BGGR=11.
  localparam logic [1:0] PHASE = 2'(BAYER_ORDER);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_LEAD,
    ST_LINE,
    ST_H_GAP,
    ST_V_GAP
  } state_t;

  state_t      r_state;
  logic [15:0] r_col;
  logic [15:0] r_row;
  logic [15:0] r_blank;

  logic        w_inLine;
  logic        w_fval;
  logic        w_lastPixel;
  logic        w_enterLead;
  logic [1:0]  w_sel;
  logic [11:0] w_pixel;

  assign w_inLine    = (r_state == ST_LINE);
  assign w_fval      = (r_state == ST_V_LEAD) || w_inLine || (r_state == ST_H_GAP);
  assign w_lastPixel = w_inLine && (r_col == H_LAST) && (r_row == V_LAST);

  // A new frame starts from IDLE or straight out of the last V_GAP cycle.
  // The underrun flag clears on exactly this transition.
  assign w_enterLead = iENABLE &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_V_GAP) && (r_blank == VB_LAST)));

  // Only the LSBs of the position matter for the 2x2 Bayer tile; XOR with
  // the phase rotates the tile so one decoder covers all four orders.
  assign w_sel = {r_row[0], r_col[0]} ^ PHASE;

  always_comb begin
    w_pixel = iGreen;
    case (w_sel)
      2'b00:   w_pixel = iRed;
      2'b11:   w_pixel = iBlue;
      default: w_pixel = iGreen;
    endcase
  end

  // The frame reader is only drained while a line is being sent, whatever
  // iVALID says; outside LINE the upstream has to hold its pixel.
  assign oREADY = w_inLine;

  // Timing FSM plus the output register. The outputs always describe the
  // state of the previous cycle, so FVAL/LVAL/X/Y/data stay aligned with
  // each other. A missing pixel never stalls the timing: it goes out as 0
  // and the sticky underrun flag records it.
  always_ff @(posedge CCD_PIXCLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_blank     <= '0;
      mCCD_DATA   <= '0;
      CCD_FVAL    <= 1'b0;
      CCD_LVAL    <= 1'b0;
      X_Cont      <= '0;
      Y_Cont      <= '0;
      oUNDERRUN   <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      CCD_FVAL    <= w_fval;
      CCD_LVAL    <= w_inLine;
      X_Cont      <= w_inLine ? r_col : '0;
      Y_Cont      <= w_inLine ? r_row : '0;
      mCCD_DATA   <= (w_inLine && iVALID) ? w_pixel : '0;
      oFRAME_DONE <= w_lastPixel;

      // Setting takes priority over the frame-start clear.
      if (w_inLine && !iVALID) begin
        oUNDERRUN <= 1'b1;
      end else if (w_enterLead) begin
        oUNDERRUN <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (iENABLE) begin
            r_state <= ST_V_LEAD;
            r_blank <= '0;
          end
        end

        ST_V_LEAD: begin
          if (r_blank == FL_LAST) begin
            r_state <= ST_LINE;
            r_blank <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end else begin
            r_blank <= r_blank + 16'd1;
          end
        end

        ST_LINE: begin
          if (r_col == H_LAST) begin
            r_col   <= '0;
            r_blank <= '0;
            if (r_row == V_LAST) begin
              r_row   <= '0;
              r_state <= ST_V_GAP;
            end else begin
              r_state <= ST_H_GAP;
            end
          end else begin
            r_col <= r_col + 16'd1;
          end
        end

        ST_H_GAP: begin
          if (r_blank == HB_LAST) begin
            r_state <= ST_LINE;
            r_row   <= r_row + 16'd1;
            r_blank <= '0;
          end else begin
            r_blank <= r_blank + 16'd1;
          end
        end

        ST_V_GAP: begin
          if (r_blank == VB_LAST) begin
            r_state <= iENABLE ? ST_V_LEAD : ST_IDLE;
            r_blank <= '0;
          end else begin
            r_blank <= r_blank + 16'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2bayer_tx.sv
// ---------------------------------------------------------------------------
// tb_rgb2bayer_tx
//
// Bench for rgb2bayer_tx with a small frame (4x2 active, 2 H-blank, 3 V-blank,
// 1 lead cycle). Two instances share all inputs: one RGGB and one BGGR.
// The reference model tracks the position inside the frame as one cycle
// index and derives the timing from it with plain arithmetic. Colours come
// from a per-order 2x2 tile lookup.
// ---------------------------------------------------------------------------
module tb_rgb2bayer_tx;

  localparam int H      = 4;
  localparam int V      = 2;
  localparam int HB     = 2;
  localparam int VB     = 3;
  localparam int FL     = 1;
  localparam int LINE_LEN = H + HB;
  localparam int ACTIVE_SPAN = V * H + (V - 1) * HB;
  localparam int PERIOD = FL + ACTIVE_SPAN + VB;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic [11:0] red, green, blue;
  logic        valid;

  logic        aReady, aFval, aLval, aUnder, aDone;
  logic [11:0] aData;
  logic [15:0] aX, aY;
  logic        bReady, bFval, bLval, bUnder, bDone;
  logic [11:0] bData;
  logic [15:0] bX, bY;

  int checks = 0;
  int errors = 0;

  int mPos   = -1;
  bit mUnder = 1'b0;

  always #5 clk = ~clk;

  rgb2bayer_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB),
                 .FV_LEAD(FL), .BAYER_ORDER(0)) dutA (
    .CCD_PIXCLK(clk), .RST_N(rstN), .iENABLE(enable),
    .iRed(red), .iGreen(green), .iBlue(blue), .iVALID(valid),
    .oREADY(aReady), .mCCD_DATA(aData), .CCD_FVAL(aFval), .CCD_LVAL(aLval),
    .X_Cont(aX), .Y_Cont(aY), .oUNDERRUN(aUnder), .oFRAME_DONE(aDone));

  rgb2bayer_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB),
                 .FV_LEAD(FL), .BAYER_ORDER(3)) dutB (
    .CCD_PIXCLK(clk), .RST_N(rstN), .iENABLE(enable),
    .iRed(red), .iGreen(green), .iBlue(blue), .iVALID(valid),
    .oREADY(bReady), .mCCD_DATA(bData), .CCD_FVAL(bFval), .CCD_LVAL(bLval),
    .X_Cont(bX), .Y_Cont(bY), .oUNDERRUN(bUnder), .oFRAME_DONE(bDone));

  typedef struct {
    bit          en;
    bit          vld;
    bit          expReady;
    bit          expFval;
    bit          expLval;
    int          expX;
    int          expY;
    logic [11:0] expD0;
    logic [11:0] expD3;
    bit          expDone;
  } vec_t;

  vec_t vecs[16];

  // Generic compare: one line per failure, counters shared by all checks.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Timing at a frame position; pos < 0 means idle.
  function automatic void phaseOf(input int pos, output bit fv, output bit lv,
                                  output int col, output int row);
    int q;
    fv = 0; lv = 0; col = 0; row = 0;
    if (pos < 0) return;
    if (pos < FL) begin
      fv = 1;
      return;
    end
    q = pos - FL;
    if (q < ACTIVE_SPAN) begin
      fv = 1;
      if ((q % LINE_LEN) < H) begin
        lv  = 1;
        col = q % LINE_LEN;
        row = q / LINE_LEN;
      end
    end
  endfunction

  // Colour of a site from the 2x2 tile of the given order.
  function automatic logic [11:0] pick(input int order, input int row, input int col,
                                       input logic [11:0] r, input logic [11:0] g,
                                       input logic [11:0] b);
    string tile;
    byte   c;
    tile = (order == 0) ? "RGGB" : "BGGR";
    c = tile[(row % 2) * 2 + (col % 2)];
    if (c == "R") return r;
    if (c == "B") return b;
    return g;
  endfunction

  // One clock: drive inputs, check oREADY, advance the model, check outputs.
  task automatic applyStimulus(input bit en, input bit vld, input bit rst_n,
                               input logic [11:0] r, input logic [11:0] g,
                               input logic [11:0] b);
    bit          fv, lv;
    int          col, row, nextPos;
    logic [11:0] d0, d3;
    bit          done;
    enable = en; valid = vld; rstN = rst_n; red = r; green = g; blue = b;
    phaseOf(mPos, fv, lv, col, row);
    checkOutput("readyA", 64'(aReady), 64'(lv));
    checkOutput("readyB", 64'(bReady), 64'(lv));
    if (!rst_n) begin
      fv = 0; lv = 0; col = 0; row = 0; d0 = 0; d3 = 0; done = 0;
      mPos = -1; mUnder = 0;
    end else begin
      d0   = (lv && vld) ? pick(0, row, col, r, g, b) : 12'h000;
      d3   = (lv && vld) ? pick(3, row, col, r, g, b) : 12'h000;
      done = lv && (col == H - 1) && (row == V - 1);
      if (mPos < 0 || mPos == PERIOD - 1) nextPos = en ? 0 : -1;
      else nextPos = mPos + 1;
      if (lv && !vld) mUnder = 1;
      else if (nextPos == 0) mUnder = 0;
      mPos = nextPos;
    end
    @(posedge clk);
    #1;
    checkOutput("outA", {16'h0, aFval, aLval, aX, aY, aData, aUnder, aDone},
                {16'h0, fv, lv, 16'(col), 16'(row), d0, mUnder, done});
    checkOutput("outB", {16'h0, bFval, bLval, bX, bY, bData, bUnder, bDone},
                {16'h0, fv, lv, 16'(col), 16'(row), d3, mUnder, done});
  endtask

  task automatic resetDut();
    applyStimulus(0, 0, 0, 12'h0, 12'h0, 12'h0);
    applyStimulus(0, 0, 0, 12'h0, 12'h0, 12'h0);
  endtask

  function automatic vec_t mk(input bit rdy, input bit fv, input bit lv, input int x,
                              input int y, input logic [11:0] d0,
                              input logic [11:0] d3, input bit done);
    vec_t v;
    v.en = 1; v.vld = 1; v.expReady = rdy; v.expFval = fv; v.expLval = lv;
    v.expX = x; v.expY = y; v.expD0 = d0; v.expD3 = d3; v.expDone = done;
    return v;
  endfunction

  initial begin
    int readyCount;
    int doneCount;
    bit lateActivity;

    // Hand-derived frame with R=111 G=222 B=333, enable applied before edge 0.
    vecs[0]  = mk(0, 0, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[2]  = mk(1, 1, 1, 0, 0, 12'h111, 12'h333, 0);
    vecs[3]  = mk(1, 1, 1, 1, 0, 12'h222, 12'h222, 0);
    vecs[4]  = mk(1, 1, 1, 2, 0, 12'h111, 12'h333, 0);
    vecs[5]  = mk(1, 1, 1, 3, 0, 12'h222, 12'h222, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[8]  = mk(1, 1, 1, 0, 1, 12'h222, 12'h222, 0);
    vecs[9]  = mk(1, 1, 1, 1, 1, 12'h333, 12'h111, 0);
    vecs[10] = mk(1, 1, 1, 2, 1, 12'h222, 12'h222, 0);
    vecs[11] = mk(1, 1, 1, 3, 1, 12'h333, 12'h111, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 12'h000, 12'h000, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 12'h000, 12'h000, 0);

    $display("[TB] start");
    resetDut();
    checkOutput("reset_state", {aFval, aLval, aX, aY, aData, aUnder, aDone, aReady}, '0);

    // Timing, mosaic and backpressure from the table.
    readyCount = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 14 && aReady) readyCount++;
      checkOutput($sformatf("tbl%0d_ready", i), 64'(aReady), 64'(vecs[i].expReady));
      applyStimulus(vecs[i].en, vecs[i].vld, 1, 12'h111, 12'h222, 12'h333);
      checkOutput($sformatf("tbl%0d_timing", i), {aFval, aLval, aX, aY, aDone},
                  {vecs[i].expFval, vecs[i].expLval, 16'(vecs[i].expX),
                   16'(vecs[i].expY), vecs[i].expDone});
      checkOutput($sformatf("tbl%0d_rggb", i), 64'(aData), 64'(vecs[i].expD0));
      checkOutput($sformatf("tbl%0d_bggr", i), 64'(bData), 64'(vecs[i].expD3));
    end
    checkOutput("pixels_per_frame", 64'(readyCount), 64'd8);

    // Single missing pixel at (2,1).
    resetDut();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, (i != 10), 1, 12'h0AB, 12'h0CD, 12'h0EF);
      if (i == 9)  checkOutput("under_before", 64'(aUnder), 64'd0);
      if (i == 10) checkOutput("under_pixel", {aX, aY, aData, aUnder},
                               {16'd2, 16'd1, 12'h000, 1'b1});
      if (i == 13) checkOutput("under_vgap", 64'(aUnder), 64'd1);
      if (i == 14) checkOutput("under_cleared", 64'(aUnder), 64'd0);
    end

    // Enable dropped during row 0: frame completes, then stays idle.
    resetDut();
    doneCount = 0;
    lateActivity = 0;
    for (int i = 0; i < 31; i++) begin
      applyStimulus((i < 3), 1, 1, 12'h123, 12'h456, 12'h789);
      if (aDone) doneCount++;
      if (i >= 12 && (aFval || aReady)) lateActivity = 1;
    end
    checkOutput("stop_done_once", 64'(doneCount), 64'd1);
    checkOutput("stop_quiet", 64'(lateActivity), 64'd0);

    // Reset while pixel x=1,y=0 is being sent.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 12'h111, 12'h222, 12'h333);
    applyStimulus(1, 1, 0, 12'h111, 12'h222, 12'h333);
    checkOutput("midreset_zero", {aFval, aLval, aX, aY, aData, aUnder, aDone}, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 12'h111, 12'h222, 12'h333);
    checkOutput("midreset_restart", {aLval, aX, aY}, {1'b1, 16'd0, 16'd0});

    // Randomized traffic against the model.
    resetDut();
    for (int i = 0; i < 900; i++) begin
      applyStimulus(($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 85),
                    ($urandom_range(0, 299) != 0), 12'($urandom), 12'($urandom),
                    12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb2bayer_tx.md
Name: rgb2bayer_tx

Overview:
- Sensor-side transmitter for the Bayer-to-RGB path: re-mosaics a stream of 12-bit RGB pixels into a single 12-bit Bayer raw stream.
- Generates CCD-style frame/line timing (FVAL, LVAL, X/Y counters) identical to what the D8M camera front end presents.
- Drives the raw capture/demosaic path from a software-generated or looped-back image, with no camera attached.
- Inputs arrive over a valid/ready handshake from a frame reader; all logic runs on one pixel clock.

Parameters:
H_ACTIVE, 640, pixels per line (LVAL high cycles), >=2, even
V_ACTIVE, 480, lines per frame, >=2, even
H_BLANK, 160, LVAL-low cycles between lines inside a frame, >=1
V_BLANK, 2000, FVAL-low cycles between frames, >=1
FV_LEAD, 4, cycles with FVAL high and LVAL low before the first line, >=1
BAYER_ORDER, 0, mosaic phase: 0=RGGB 1=GRBG 2=GBRG 3=BGGR

Ports:
CCD_PIXCLK  in  1  pixel clock; all logic on its rising edge
RST_N  in  1  synchronous active-low reset
iENABLE  in  1  start frames; sampled only in IDLE and at the end of V_GAP
iRed  in  12  red component of the offered pixel
iGreen  in  12  green component of the offered pixel
iBlue  in  12  blue component of the offered pixel
iVALID  in  1  offered pixel valid
oREADY  out  1  pixel consumed this cycle when iVALID=1
mCCD_DATA  out  12  Bayer raw sample
CCD_FVAL  out  1  frame valid
CCD_LVAL  out  1  line valid
X_Cont  out  16  column of the current mCCD_DATA sample
Y_Cont  out  16  row of the current mCCD_DATA sample
oUNDERRUN  out  1  sticky: a pixel was missing in the current frame
oFRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (RST_N=0 at a clock edge), also mid-frame:
  - state=IDLE; all outputs 0; internal counters 0.
  - The partial frame is abandoned; no FRAME_DONE pulse.
- States and transitions:
  - IDLE -> V_LEAD when iENABLE=1.
  - V_LEAD: FV_LEAD cycles, then LINE.
  - LINE: H_ACTIVE cycles, then H_GAP, or V_GAP after line V_ACTIVE-1.
  - H_GAP: H_BLANK cycles, then LINE with row+1.
  - V_GAP: V_BLANK cycles, then V_LEAD if iENABLE=1, else IDLE.
- State-phase signals, before the output register:
  - fval=1 in V_LEAD, LINE and H_GAP.
  - lval=1 in LINE only.
- oREADY is combinational: 1 exactly in LINE, 0 elsewhere. It does not depend on iVALID.
- Output register (latency 1): the cycle after state cycle t, the outputs carry state t's values:
  - CCD_FVAL, CCD_LVAL, X_Cont = column, Y_Cont = row, mCCD_DATA.
  - X_Cont and Y_Cont are 0 when LVAL is low.
- Channel select uses p = {row[0], col[0]} XOR phase. Phase per BAYER_ORDER: 0 -> 00, 1 -> 01, 2 -> 10, 3 -> 11.
  - p=00 selects red.
  - p=01 and p=10 select green.
  - p=11 selects blue.
- Underrun: in LINE with iVALID=0:
  - mCCD_DATA=0 for that pixel; timing does not stall.
  - oUNDERRUN is set and stays set until V_LEAD entry, where it clears.
  - If an underrun and V_LEAD entry coincide, the set wins. This cannot occur in practice, since oREADY=0 in V_LEAD.
- Pixels offered outside LINE are not consumed; upstream must hold them.
- oFRAME_DONE: 1 in the cycle the last LINE pixel of row V_ACTIVE-1 appears on the outputs.
- Counters: column 0..H_ACTIVE-1 and row 0..V_ACTIVE-1.
  - Both wrap to 0 at end of line and end of frame respectively.
  - Blank counters reload on each state entry.
- iENABLE dropped mid-frame: the current frame completes normally; the transmitter then stops in IDLE after V_GAP.
- Frame period = FV_LEAD + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK cycles.
- Widths: no arithmetic on pixel data; counters are 16-bit internally.

Test Plan:
Bench parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3, FV_LEAD=1.
1. Reset then iENABLE=1, constant iVALID=1 -> FVAL rises 2 cycles after enable. LVAL bursts are 4 cycles with a 2-cycle gap. Frame period is 1+8+2+3=14 cycles. X_Cont runs 0,1,2,3; Y_Cont is 0 then 1.
2. BAYER_ORDER=0, pixel R=0x111 G=0x222 B=0x333 -> row 0 = 111,222,111,222; row 1 = 222,333,222,333. With BAYER_ORDER=3, row 0 = 333,222,333,222.
3. iVALID=0 for pixel (x=2, y=1) only -> that sample is 000, oUNDERRUN goes 1 on the same output cycle and stays 1 through V_GAP. It clears when the next frame's V_LEAD begins.
4. iENABLE deasserted during row 0 -> rows 0 and 1 both complete, then oFRAME_DONE pulses once. FVAL then stays 0 and oREADY stays 0 indefinitely.
5. RST_N=0 at pixel x=1, y=0 -> the next cycle has all outputs 0 and no FRAME_DONE. After release with iENABLE=1, the next frame starts at x=0, y=0.
6. Backpressure check -> oREADY is never 1 outside LVAL phase cycles. Exactly 8 pixels are consumed per frame.
